imem_line_fetch: RTL and testbench
==================================

IMEM_LINE_FETCH -- requirements
Module: imem_line_fetch

Interface
REQ-001 Parameter: TIMEOUT, 64, max cycles waited for word_ack on any one beat before abort; legal range 2..255.
REQ-002 Port: CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-low reset.
REQ-004 Port: req  input  1  line request from L1 instruction cache (its mem_req).
REQ-005 Port: req_addr  input  32  byte address of requested line (its mem_address).
REQ-006 Port: line_data  output  256  assembled 32-byte line (to cache mem_data).
REQ-007 Port: line_valid  output  1  one-cycle pulse, line_data complete (to cache mem_valid).
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: err  output  1  one-cycle pulse on timeout abort.
REQ-010 Port: word_rd  output  1  read strobe to 32-bit main memory.
REQ-011 Port: word_addr  output  32  word-aligned main-memory read address.
REQ-012 Port: word_data  input  32  read data, valid when word_ack high.
REQ-013 Port: word_ack  input  1  memory accepts word_rd and returns word_data in the same cycle.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, DONE; all outputs registered.
REQ-015 IDLE: req high at an edge -> latch line_addr = {req_addr[31:5],5'b0}; clear beat (3 bits) and wait counter; go FETCH; line_data cleared to 0 on accept.
REQ-016 IDLE, req low: remain; word_rd=0, busy=0.
REQ-017 FETCH: word_rd=1, word_addr = line_addr + 4*beat; both held stable until word_ack.
REQ-018 FETCH, word_ack high: word_data written to line_data[255-32*beat -: 32] (beat 0 -> [255:224], beat 7 -> [31:0]); beat increments; wait counter clears.
REQ-019 FETCH, word_ack on beat 7: next state DONE; line_valid=1 in the DONE cycle.
REQ-020 DONE: lasts exactly one cycle, then IDLE unconditionally; req high during DONE is not a new request.
REQ-021 With zero-wait memory (word_ack every FETCH cycle): line_valid high 9 cycles after the accepting edge.
REQ-022 line_data SHALL hold its value from DONE until the next request is accepted.
REQ-023 req deasserted during FETCH: fetch continues to completion; line_valid still pulses.
REQ-024 Wait counter increments each FETCH cycle without word_ack; reaching TIMEOUT -> err=1 for one cycle, go IDLE, no line_valid, line_data keeps partial contents.
REQ-025 word_ack outside FETCH SHALL be ignored (no capture, no state change).
REQ-026 line_addr computation ignores req_addr[4:0]; address arithmetic wraps modulo 2^32 (no carry into state).
REQ-027 line_valid and err SHALL never be high in the same cycle.

Reset
REQ-028 RESET low at an edge, from any state including mid-FETCH: state IDLE; line_data=0, line_valid=0, busy=0, err=0, word_rd=0, word_addr=0; beat and wait counter 0.
REQ-029 req high in the first cycle after reset release SHALL be accepted normally.

Verification
REQ-030 req=1, req_addr=0x0000_1234, zero-wait memory returning word = address -> word_addr 0x1220..0x123C; line_valid after 9 cycles; line_data[255:224]=0x1220, [31:0]=0x123C.
REQ-031 Same request, word_ack delayed 3 cycles on beat 4 -> word_rd/word_addr=0x1230 held 4 cycles; line_valid at cycle 12; data identical to REQ-030.
REQ-032 word_ack never asserted on beat 2, TIMEOUT=64 -> err pulses once after 64 wait cycles; busy drops; line_valid stays 0.
REQ-033 RESET low during beat 5 -> next cycle all outputs 0, state IDLE; fresh req completes a clean line.
REQ-034 req dropped after beat 1 -> all 8 beats still fetched, line_valid pulses once; req held high through DONE -> exactly one fetch.
REQ-035 req_addr=0xFFFF_FFE4 -> word_addr 0xFFFF_FFE0..0xFFFF_FFFC, no wrap beyond line; spurious word_ack in IDLE -> no effect.

Source files
------------

// File: rtl/imem_line_fetch.sv
// Line-fill engine for the L1 instruction cache: fetches one 32-byte line as
// eight 32-bit beats from main memory and presents it as a single 256-bit word.
module imem_line_fetch #(
    parameter int TIMEOUT = 64
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         req,
    input  logic [31:0]  req_addr,
    output logic [255:0] line_data,
    output logic         line_valid,
    output logic         busy,
    output logic         err,
    output logic         word_rd,
    output logic [31:0]  word_addr,
    input  logic [31:0]  word_data,
    input  logic         word_ack
);

    // Memory handshake: word_rd/word_addr are held steady until a cycle in
    // which word_ack is high; that cycle both accepts the read and returns data.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    state_t         state_q, state_d;
    logic [31:0]    line_addr_q, line_addr_d;
    logic [2:0]     beat_q, beat_d;
    logic [7:0]     wait_q, wait_d;
    logic [255:0]   line_data_q, line_data_d;
    logic           line_valid_q, line_valid_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic           word_rd_q, word_rd_d;
    logic [31:0]    word_addr_q, word_addr_d;

    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        beat_d       = beat_q;
        wait_d       = wait_q;
        line_data_d  = line_data_q;
        line_valid_d = 1'b0;
        err_d        = 1'b0;
        word_rd_d    = word_rd_q;
        word_addr_d  = word_addr_q;

        case (state_q)
            IDLE: begin
                word_rd_d = 1'b0;
                if (req) begin
                    line_addr_d = {req_addr[31:5], 5'b0};
                    word_addr_d = {req_addr[31:5], 5'b0};
                    beat_d      = 3'd0;
                    wait_d      = 8'd0;
                    line_data_d = '0;
                    word_rd_d   = 1'b1;
                    state_d     = FETCH;
                end
            end

            FETCH: begin
                if (word_ack) begin
                    // Beat 0 lands in the most significant word of the line.
                    for (int k = 0; k < 8; k++) begin
                        if (beat_q == 3'(k)) begin
                            line_data_d[255 - 32*k -: 32] = word_data;
                        end
                    end
                    wait_d = 8'd0;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        word_rd_d    = 1'b0;
                        line_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        word_addr_d = line_addr_q + {27'd0, beat_d, 2'b00};
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_d == TIMEOUT_W) begin
                        word_rd_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end

            DONE: begin
                word_rd_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                word_rd_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= IDLE;
            line_addr_q  <= '0;
            beat_q       <= '0;
            wait_q       <= '0;
            line_data_q  <= '0;
            line_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            word_rd_q    <= 1'b0;
            word_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            line_data_q  <= line_data_d;
            line_valid_q <= line_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            word_rd_q    <= word_rd_d;
            word_addr_q  <= word_addr_d;
        end
    end

    assign line_data  = line_data_q;
    assign line_valid = line_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign word_rd    = word_rd_q;
    assign word_addr  = word_addr_q;

    a_valid_err_excl: assert property (@(posedge CLK) disable iff (!RESET)
        !(line_valid_q && err_q));

    a_rd_implies_busy: assert property (@(posedge CLK) disable iff (!RESET)
        word_rd_q |-> busy_q);

    a_addr_stable: assert property (@(posedge CLK) disable iff (!RESET)
        (word_rd_q && !word_ack) |=> $stable(word_addr_q));

endmodule

// File: tb/tb_imem_line_fetch.sv
// Bench for imem_line_fetch: randomized line fetches against a queue-based
// reference of addresses, line contents, completion kind and latency.
module tb_imem_line_fetch;

    localparam int TO = 64;

    logic         CLK;
    logic         RESET;
    logic         req;
    logic [31:0]  req_addr;
    logic [255:0] line_data;
    logic         line_valid;
    logic         busy;
    logic         err;
    logic         word_rd;
    logic [31:0]  word_addr;
    logic [31:0]  word_data;
    logic         word_ack;

    imem_line_fetch #(.TIMEOUT(TO)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req        (req),
        .req_addr   (req_addr),
        .line_data  (line_data),
        .line_valid (line_valid),
        .busy       (busy),
        .err        (err),
        .word_rd    (word_rd),
        .word_addr  (word_addr),
        .word_data  (word_data),
        .word_ack   (word_ack)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_errs   = 0;
    logic [31:0]  exp_addr_q[$];
    logic [256:0] exp_q[$];        // bit 256 set = timeout abort, else line
    int           delays[8];       // stall cycles per beat, -1 = never ack
    logic [31:0]  mem_seed;
    int           beat_idx;
    int           stall_cnt;
    int           rd_cycles;
    bit           spurious_en;

    function automatic void chk(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void clear_delays();
        for (int k = 0; k < 8; k++) delays[k] = 0;
    endfunction

    // ---------------- memory responder ----------------
    // Memory word at address a is a ^ mem_seed.
    initial begin : responder
        logic [31:0] e;
        word_ack  = 1'b0;
        word_data = '0;
        forever begin
            @(negedge CLK);
            word_ack = 1'b0;
            if (word_rd) begin
                rd_cycles++;
                if (beat_idx < 8 && delays[beat_idx] >= 0 && stall_cnt >= delays[beat_idx]) begin
                    word_ack  = 1'b1;
                    word_data = word_addr ^ mem_seed;
                    if (exp_addr_q.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL unexpected_read: got addr %0h expected no read", word_addr);
                    end else begin
                        e = exp_addr_q.pop_front();
                        chk("word_addr", 256'(word_addr), 256'(e));
                    end
                    stall_cnt = 0;
                    beat_idx++;
                end else begin
                    stall_cnt++;
                end
            end else if (spurious_en) begin
                word_ack  = 1'($urandom_range(0, 1));
                word_data = $urandom;
            end
        end
    end

    // ---------------- output monitor ----------------
    initial begin : monitor
        logic [256:0] e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                if (line_valid && err) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL valid_err_same_cycle: got both high expected at most one");
                end
                if (line_valid || err) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL unexpected_event: got valid=%0b err=%0b expected none", line_valid, err);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind_err", 256'(err), 256'(e[256]));
                        chk("event_line_data", line_data, e[255:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_req(input logic [31:0] addr, input logic [31:0] seed, input int drop_cyc);
        logic [31:0]  la;
        logic [31:0]  wa;
        logic [255:0] line;
        int           hang;
        int           nfetch;
        int           cyc;
        bit           done;
        la     = {addr[31:5], 5'b0};
        line   = '0;
        hang   = -1;
        nfetch = 0;
        for (int k = 0; k < 8; k++) begin
            if (hang < 0) begin
                if (delays[k] < 0) begin
                    hang = k;
                end else begin
                    wa = la + 32'(4 * k);
                    exp_addr_q.push_back(wa);
                    line[255 - 32*k -: 32] = wa ^ seed;
                    nfetch += 1 + delays[k];
                end
            end
        end
        if (hang >= 0) nfetch += TO;
        exp_q.push_back({hang >= 0, line});

        mem_seed  = seed;
        beat_idx  = 0;
        stall_cnt = 0;
        rd_cycles = 0;
        req_addr  = addr;
        req       = 1'b1;
        @(posedge CLK); #1;
        cyc = 1;
        chk("accept_busy", 256'(busy), 256'(1));
        chk("accept_word_rd", 256'(word_rd), 256'(1));
        chk("accept_word_addr", 256'(word_addr), 256'(la));
        chk("accept_line_clear", line_data, '0);

        done = 1'b0;
        while (!done && cyc < 500) begin
            if (line_valid || err) begin
                done = 1'b1;
            end else begin
                if (cyc >= drop_cyc) req = 1'b0;
                @(posedge CLK); #1;
                cyc++;
            end
        end
        if (!done) begin
            n_checks++;
            n_errs++;
            $display("FAIL no_completion: got nothing expected pulse within 500 cycles");
        end
        chk("completion_cycle", 256'(cyc), 256'(nfetch + 1));
        chk("read_cycles", 256'(rd_cycles), 256'(nfetch));
        chk("busy_at_completion", 256'(busy), 256'(hang < 0));
        if (err) req = 1'b0;

        @(posedge CLK); #1;
        req = 1'b0;
        chk("idle_busy", 256'(busy), 256'(0));
        chk("idle_word_rd", 256'(word_rd), 256'(0));
        chk("held_line_data", line_data, line);
        chk("addr_queue_drained", 256'(exp_addr_q.size()), 256'(0));
        @(posedge CLK); #1;
        chk("no_reaccept", 256'(busy), 256'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] la;
        int          n;
        int          h;
        RESET       = 1'b0;
        req         = 1'b0;
        req_addr    = '0;
        spurious_en = 1'b0;
        mem_seed    = '0;
        beat_idx    = 0;
        stall_cnt   = 0;
        rd_cycles   = 0;
        clear_delays();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_line_data", line_data, '0);
        chk("reset_line_valid", 256'(line_valid), 256'(0));
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_err", 256'(err), 256'(0));
        chk("reset_word_rd", 256'(word_rd), 256'(0));
        chk("reset_word_addr", 256'(word_addr), 256'(0));
        RESET = 1'b1;

        // Zero-wait memory returning word = address.
        run_req(32'h0000_1234, 32'h0, 1);
        chk("line_first_word", 256'(line_data[255:224]), 256'(32'h0000_1220));
        chk("line_last_word", 256'(line_data[31:0]), 256'(32'h0000_123C));

        // Three-cycle stall on beat 4.
        delays[4] = 3;
        run_req(32'h0000_1234, 32'h0, 1);
        clear_delays();

        // Beat 2 never acknowledged: timeout abort.
        delays[2] = -1;
        run_req(32'h0000_1234, 32'h0, 1);
        clear_delays();

        // Reset during beat 5, then a request in the first cycle after release.
        la = 32'h0000_4000;
        for (int k = 0; k < 8; k++) exp_addr_q.push_back(la + 32'(4 * k));
        mem_seed  = 32'h5A5A_0F0F;
        beat_idx  = 0;
        stall_cnt = 0;
        req_addr  = 32'h0000_4010;
        req       = 1'b1;
        @(posedge CLK); #1;
        req = 1'b0;
        n = 0;
        while (beat_idx != 5 && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("beat5_word_addr", 256'(word_addr), 256'(la + 32'd20));
        RESET = 1'b0;
        @(posedge CLK); #1;
        chk("midfetch_reset_line_data", line_data, '0);
        chk("midfetch_reset_line_valid", 256'(line_valid), 256'(0));
        chk("midfetch_reset_busy", 256'(busy), 256'(0));
        chk("midfetch_reset_err", 256'(err), 256'(0));
        chk("midfetch_reset_word_rd", 256'(word_rd), 256'(0));
        chk("midfetch_reset_word_addr", 256'(word_addr), 256'(0));
        exp_addr_q.delete();
        exp_q.delete();
        RESET = 1'b1;
        run_req(32'h0000_4010, 32'h1357_9BDF, 1);

        // req dropped after beat 1; then req held high through DONE.
        run_req(32'h0000_8000, 32'hDEAD_BEEF, 3);
        run_req(32'h0000_8040, 32'hCAFE_F00D, 1000);

        // Top-of-memory line with spurious acks while idle.
        spurious_en = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("spurious_ack_busy", 256'(busy), 256'(0));
        run_req(32'hFFFF_FFE4, 32'h0, 1);

        // Randomized traffic.
        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < 8; k++) delays[k] = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                h = $urandom_range(0, 7);
                delays[h] = -1;
            end
            run_req($urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(1, 20)));
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
        end
        clear_delays();

        chk("event_queue_drained", 256'(exp_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
